// File: rtl/hazard_if.sv
// Pipeline-side bundle between the 5-stage datapath (master) and the hazard unit (slave).
interface hazard_if #(
    parameter int unsigned RW = 5,
    parameter int unsigned CW = 16
);
    logic [RW-1:0] ID_rs, ID_rt, ID_RW;
    logic          ID_rs_used, ID_rt_used, ID_regwe, ID_branch, ID_longop;
    logic [RW-1:0] EX_rs, EX_rt, EX_RW;
    logic          EX_regwe, EX_memread;
    logic [RW-1:0] MEM_rt, MEM_RW;
    logic          MEM_regwe, MEM_memread, MEM_ramwe;
    logic [RW-1:0] WB_RW;
    logic          WB_regwe;
    logic          mem_ready;

    logic [1:0]    ID_forwardA, ID_forwardB;
    logic [1:0]    EX_forwardA, EX_forwardB;
    logic          MEM_forward;
    logic          stall, bubble, freeze;
    logic          long_issue, long_busy, long_done;
    logic [CW-1:0] stall_cycles;

    modport master (
        output ID_rs, ID_rt, ID_RW, ID_rs_used, ID_rt_used, ID_regwe, ID_branch, ID_longop,
        output EX_rs, EX_rt, EX_RW, EX_regwe, EX_memread,
        output MEM_rt, MEM_RW, MEM_regwe, MEM_memread, MEM_ramwe,
        output WB_RW, WB_regwe, mem_ready,
        input  ID_forwardA, ID_forwardB, EX_forwardA, EX_forwardB, MEM_forward,
        input  stall, bubble, freeze, long_issue, long_busy, long_done, stall_cycles
    );

    modport slave (
        input  ID_rs, ID_rt, ID_RW, ID_rs_used, ID_rt_used, ID_regwe, ID_branch, ID_longop,
        input  EX_rs, EX_rt, EX_RW, EX_regwe, EX_memread,
        input  MEM_rt, MEM_RW, MEM_regwe, MEM_memread, MEM_ramwe,
        input  WB_RW, WB_regwe, mem_ready,
        output ID_forwardA, ID_forwardB, EX_forwardA, EX_forwardB, MEM_forward,
        output stall, bubble, freeze, long_issue, long_busy, long_done, stall_cycles
    );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding selects, load-use/branch/memory stalls and a single-entry scoreboard
// for the non-pipelined long-latency unit of the 5-stage pipeline.
module hazard_unit #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned LONG_LATENCY   = 4,
    parameter int unsigned BRANCH_IN_ID   = 1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave hz_io
);
    localparam int unsigned RW    = REG_ADDR_WIDTH;
    localparam int unsigned LAT_W = (LONG_LATENCY > 2) ? $clog2(LONG_LATENCY) : 1;
    localparam logic        BR_EN = (BRANCH_IN_ID != 0);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e               state_q, state_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]        pend_rw_q, pend_rw_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic long_busy, long_done, long_issue;
    logic rs_op, rt_op, hz_load, hz_branch, hz_long, freeze, stall;
    logic [1:0] id_fwd_a, id_fwd_b;

    function automatic logic eq_nz(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // EX and store-data forwarding: the younger producer in MEM wins over WB
    assign hz_io.EX_forwardA = (hz_io.MEM_regwe && eq_nz(hz_io.EX_rs, hz_io.MEM_RW)) ? 2'b10 :
                               (hz_io.WB_regwe  && eq_nz(hz_io.EX_rs, hz_io.WB_RW))  ? 2'b01 : 2'b00;
    assign hz_io.EX_forwardB = (hz_io.MEM_regwe && eq_nz(hz_io.EX_rt, hz_io.MEM_RW)) ? 2'b10 :
                               (hz_io.WB_regwe  && eq_nz(hz_io.EX_rt, hz_io.WB_RW))  ? 2'b01 : 2'b00;
    assign hz_io.MEM_forward = hz_io.WB_regwe & hz_io.MEM_ramwe & eq_nz(hz_io.MEM_rt, hz_io.WB_RW);

    // ID forwarding for early branch resolution; a load in MEM has no data yet
    assign id_fwd_a = (long_done && eq_nz(pend_rw_q, hz_io.ID_rs)) ? 2'b11 :
                      (hz_io.MEM_regwe && !hz_io.MEM_memread && eq_nz(hz_io.ID_rs, hz_io.MEM_RW)) ? 2'b10 :
                      (hz_io.WB_regwe && eq_nz(hz_io.ID_rs, hz_io.WB_RW)) ? 2'b01 : 2'b00;
    assign id_fwd_b = (long_done && eq_nz(pend_rw_q, hz_io.ID_rt)) ? 2'b11 :
                      (hz_io.MEM_regwe && !hz_io.MEM_memread && eq_nz(hz_io.ID_rt, hz_io.MEM_RW)) ? 2'b10 :
                      (hz_io.WB_regwe && eq_nz(hz_io.ID_rt, hz_io.WB_RW)) ? 2'b01 : 2'b00;
    assign hz_io.ID_forwardA = BR_EN ? id_fwd_a : 2'b00;
    assign hz_io.ID_forwardB = BR_EN ? id_fwd_b : 2'b00;

    assign rs_op = hz_io.ID_rs_used & (hz_io.ID_rs != '0);
    assign rt_op = hz_io.ID_rt_used & (hz_io.ID_rt != '0);

    assign hz_load   = hz_io.EX_memread & ((rs_op && hz_io.ID_rs == hz_io.EX_RW) ||
                                           (rt_op && hz_io.ID_rt == hz_io.EX_RW));
    assign hz_branch = BR_EN & hz_io.ID_branch &
                       ((hz_io.EX_regwe   && ((rs_op && hz_io.ID_rs == hz_io.EX_RW) ||
                                              (rt_op && hz_io.ID_rt == hz_io.EX_RW))) ||
                        (hz_io.MEM_memread && ((rs_op && hz_io.ID_rs == hz_io.MEM_RW) ||
                                               (rt_op && hz_io.ID_rt == hz_io.MEM_RW))));
    // A second long op must wait: the unit is not pipelined
    assign hz_long   = long_busy & ~long_done &
                       (eq_nz(pend_rw_q, rs_op ? hz_io.ID_rs : '0) ||
                        eq_nz(pend_rw_q, rt_op ? hz_io.ID_rt : '0) ||
                        (hz_io.ID_regwe && eq_nz(pend_rw_q, hz_io.ID_RW)) ||
                        hz_io.ID_longop);

    assign freeze     = (hz_io.MEM_memread | hz_io.MEM_ramwe) & ~hz_io.mem_ready;
    assign stall      = freeze | hz_load | hz_branch | hz_long;
    assign long_issue = hz_io.ID_longop & ~stall;

    assign hz_io.freeze       = freeze;
    assign hz_io.stall        = stall;
    assign hz_io.bubble       = stall & ~freeze;
    assign hz_io.long_issue   = long_issue;
    assign hz_io.long_busy    = long_busy;
    assign hz_io.long_done    = long_done;
    assign hz_io.stall_cycles = stall_cnt_q;

    // Scoreboard state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_rw_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_rw_q <= pend_rw_d;
        end
    end

    // Scoreboard next state; the countdown keeps running through freezes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_rw_d = pend_rw_q;
        unique case (state_q)
            IDLE: begin
                if (long_issue) begin
                    state_d   = BUSY;
                    cnt_d     = LAT_W'(LONG_LATENCY - 1);
                    pend_rw_d = hz_io.ID_RW;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end else if (long_issue) begin
                    cnt_d     = LAT_W'(LONG_LATENCY - 1);
                    pend_rw_d = hz_io.ID_RW;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scoreboard outputs
    always_comb begin
        long_busy = 1'b0;
        long_done = 1'b0;
        if (state_q == BUSY) begin
            long_busy = 1'b1;
            long_done = (cnt_q == '0);
        end
    end

    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Directed scenarios plus randomized traffic against a cycle-count reference model of hazard_unit.
module tb_hazard_unit;
    localparam int unsigned RW  = 5;
    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_if #(.RW(RW), .CW(CW)) hif();

    hazard_unit #(.REG_ADDR_WIDTH(RW), .LONG_LATENCY(LAT), .BRANCH_IN_ID(1), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_io (hif)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: long unit tracked by absolute completion cycle
    int            cyc;
    bit            m_busy;
    int            m_done_cyc;
    logic [RW-1:0] m_pend;
    int            m_scnt;

    logic [1:0] e_idfa, e_idfb, e_exfa, e_exfb;
    logic       e_memf, e_stall, e_bubble, e_freeze, e_issue, e_busy, e_done;
    logic [30:0] exp_v;
    logic [30:0] got_v;

    assign got_v = {hif.ID_forwardA, hif.ID_forwardB, hif.EX_forwardA, hif.EX_forwardB, hif.MEM_forward,
                    hif.stall, hif.bubble, hif.freeze, hif.long_issue, hif.long_busy, hif.long_done,
                    hif.stall_cycles};

    function automatic bit uses(bit used, logic [RW-1:0] r, logic [RW-1:0] tgt);
        return used && r != 0 && r == tgt;
    endfunction

    function automatic logic [1:0] ex_sel(logic [RW-1:0] r);
        if (r != 0 && hif.MEM_regwe && r == hif.MEM_RW) return 2'b10;
        if (r != 0 && hif.WB_regwe && r == hif.WB_RW)   return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] id_sel(logic [RW-1:0] r, bit done);
        if (r == 0) return 2'b00;
        if (done && r == m_pend) return 2'b11;
        if (hif.MEM_regwe && !hif.MEM_memread && r == hif.MEM_RW) return 2'b10;
        if (hif.WB_regwe && r == hif.WB_RW) return 2'b01;
        return 2'b00;
    endfunction

    task automatic eval_model();
        bit hz_load, hz_branch, hz_long, rsu, rtu;
        rsu      = hif.ID_rs_used;
        rtu      = hif.ID_rt_used;
        e_busy   = m_busy;
        e_done   = m_busy && (cyc == m_done_cyc);
        e_idfa   = id_sel(hif.ID_rs, e_done);
        e_idfb   = id_sel(hif.ID_rt, e_done);
        e_exfa   = ex_sel(hif.EX_rs);
        e_exfb   = ex_sel(hif.EX_rt);
        e_memf   = hif.WB_regwe && hif.MEM_ramwe && hif.MEM_rt != 0 && hif.MEM_rt == hif.WB_RW;
        e_freeze = (hif.MEM_memread || hif.MEM_ramwe) && !hif.mem_ready;
        hz_load  = hif.EX_memread && (uses(rsu, hif.ID_rs, hif.EX_RW) || uses(rtu, hif.ID_rt, hif.EX_RW));
        hz_branch = hif.ID_branch &&
                    ((hif.EX_regwe && (uses(rsu, hif.ID_rs, hif.EX_RW) || uses(rtu, hif.ID_rt, hif.EX_RW))) ||
                     (hif.MEM_memread && (uses(rsu, hif.ID_rs, hif.MEM_RW) || uses(rtu, hif.ID_rt, hif.MEM_RW))));
        hz_long  = e_busy && !e_done &&
                   ((m_pend != 0 && (uses(rsu, hif.ID_rs, m_pend) || uses(rtu, hif.ID_rt, m_pend) ||
                                     (hif.ID_regwe && hif.ID_RW == m_pend))) || hif.ID_longop);
        e_stall  = e_freeze || hz_load || hz_branch || hz_long;
        e_bubble = e_stall && !e_freeze;
        e_issue  = hif.ID_longop && !e_stall;
        exp_v    = {e_idfa, e_idfb, e_exfa, e_exfb, e_memf, e_stall, e_bubble, e_freeze,
                    e_issue, e_busy, e_done, CW'(m_scnt)};
    endtask

    // Advance one clock: model follows the current inputs, returns at the next falling edge
    task automatic tick();
        eval_model();
        @(posedge clk);
        if (!rst) begin
            if (e_stall && m_scnt < (1 << CW) - 1) m_scnt++;
            if (e_done) m_busy = 0;
            if (e_issue) begin
                m_busy     = 1;
                m_done_cyc = cyc + LAT;
                m_pend     = hif.ID_RW;
            end
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_busy = 0; m_pend = '0; m_scnt = 0; cyc = 0; m_done_cyc = -1;
    endtask

    task automatic set_idle();
        hif.ID_rs = '0; hif.ID_rt = '0; hif.ID_RW = '0;
        hif.ID_rs_used = 0; hif.ID_rt_used = 0; hif.ID_regwe = 0; hif.ID_branch = 0; hif.ID_longop = 0;
        hif.EX_rs = '0; hif.EX_rt = '0; hif.EX_RW = '0; hif.EX_regwe = 0; hif.EX_memread = 0;
        hif.MEM_rt = '0; hif.MEM_RW = '0; hif.MEM_regwe = 0; hif.MEM_memread = 0; hif.MEM_ramwe = 0;
        hif.WB_RW = '0; hif.WB_regwe = 0; hif.mem_ready = 1;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1;
        #1;
        total++; if (got_v !== 31'd0) begin bad++; $display("FAIL reset_hold: got %h exp 0", got_v); end
        @(negedge clk);
        rst = 0;
        model_reset();
        #1;
        total++; if (got_v !== 31'd0) begin bad++; $display("FAIL reset_idle: got %h exp 0", got_v); end
        tick();
    endtask

    task automatic test_ex_fwd();
        set_idle();
        hif.EX_rs = 3; hif.MEM_RW = 3; hif.MEM_regwe = 1; hif.WB_RW = 3; hif.WB_regwe = 1;
        #1;
        total++; if (hif.EX_forwardA !== 2'b10) begin bad++; $display("FAIL exfa_mem: got %b exp 10", hif.EX_forwardA); end
        hif.MEM_regwe = 0; #1;
        total++; if (hif.EX_forwardA !== 2'b01) begin bad++; $display("FAIL exfa_wb: got %b exp 01", hif.EX_forwardA); end
        hif.EX_rs = 0; #1;
        total++; if (hif.EX_forwardA !== 2'b00) begin bad++; $display("FAIL exfa_r0: got %b exp 00", hif.EX_forwardA); end
        hif.EX_rt = 3; #1;
        total++; if (hif.EX_forwardB !== 2'b01) begin bad++; $display("FAIL exfb_wb: got %b exp 01", hif.EX_forwardB); end
        hif.MEM_ramwe = 1; hif.MEM_rt = 3; #1;
        total++; if (hif.MEM_forward !== 1'b1) begin bad++; $display("FAIL memfwd_on: got %b exp 1", hif.MEM_forward); end
        hif.MEM_rt = 0; #1;
        total++; if (hif.MEM_forward !== 1'b0) begin bad++; $display("FAIL memfwd_r0: got %b exp 0", hif.MEM_forward); end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        hif.EX_memread = 1; hif.EX_regwe = 1; hif.EX_RW = 4; hif.ID_rs = 4; hif.ID_rs_used = 1;
        #1;
        total++; if ({hif.stall, hif.bubble} !== 2'b11) begin bad++; $display("FAIL lu_stall: got %b exp 11", {hif.stall, hif.bubble}); end
        tick();
        hif.EX_memread = 0; hif.EX_regwe = 0; hif.EX_RW = 0;
        hif.MEM_memread = 1; hif.MEM_regwe = 1; hif.MEM_RW = 4;
        #1;
        total++; if (hif.stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %b exp 0", hif.stall); end
        tick();
        set_idle();
    endtask

    task automatic test_branch_load();
        do_reset();
        hif.ID_branch = 1; hif.ID_rs = 7; hif.ID_rs_used = 1;
        hif.EX_memread = 1; hif.EX_regwe = 1; hif.EX_RW = 7;
        #1;
        total++; if ({hif.stall, hif.bubble} !== 2'b11) begin bad++; $display("FAIL br_ex: got %b exp 11", {hif.stall, hif.bubble}); end
        tick();
        hif.EX_memread = 0; hif.EX_regwe = 0; hif.EX_RW = 0;
        hif.MEM_memread = 1; hif.MEM_regwe = 1; hif.MEM_RW = 7;
        #1;
        total++; if (hif.stall !== 1'b1) begin bad++; $display("FAIL br_mem: got %b exp 1", hif.stall); end
        tick();
        hif.MEM_memread = 0; hif.MEM_regwe = 0; hif.MEM_RW = 0;
        hif.WB_regwe = 1; hif.WB_RW = 7;
        #1;
        total++; if (hif.stall !== 1'b0) begin bad++; $display("FAIL br_wb_stall: got %b exp 0", hif.stall); end
        total++; if (hif.ID_forwardA !== 2'b01) begin bad++; $display("FAIL br_wb_fwd: got %b exp 01", hif.ID_forwardA); end
        total++; if (hif.stall_cycles !== CW'(2)) begin bad++; $display("FAIL br_count: got %0d exp 2", hif.stall_cycles); end
        tick();
        set_idle();
    endtask

    task automatic test_long();
        do_reset();
        hif.ID_longop = 1; hif.ID_regwe = 1; hif.ID_RW = 9;
        #1;
        total++; if (hif.long_issue !== 1'b1) begin bad++; $display("FAIL lo_issue: got %b exp 1", hif.long_issue); end
        tick();                                 // t+1
        set_idle(); #1;
        total++; if ({hif.long_busy, hif.stall} !== 2'b10) begin bad++; $display("FAIL lo_busy: got %b exp 10", {hif.long_busy, hif.stall}); end
        tick();                                 // t+2
        hif.ID_rs = 9; hif.ID_rs_used = 1; #1;
        total++; if (hif.stall !== 1'b1) begin bad++; $display("FAIL lo_raw_stall: got %b exp 1", hif.stall); end
        tick();                                 // t+3
        #1;
        total++; if ({hif.stall, hif.long_done} !== 2'b10) begin bad++; $display("FAIL lo_t3: got %b exp 10", {hif.stall, hif.long_done}); end
        tick();                                 // t+4
        hif.ID_longop = 1; hif.ID_regwe = 1; hif.ID_RW = 10; #1;
        total++; if ({hif.long_done, hif.ID_forwardA, hif.stall, hif.long_issue} !== 5'b11101) begin
            bad++; $display("FAIL lo_done: got %b exp 11101", {hif.long_done, hif.ID_forwardA, hif.stall, hif.long_issue}); end
        tick();                                 // t+5
        set_idle(); #1;
        total++; if ({hif.long_busy, hif.long_done} !== 2'b10) begin bad++; $display("FAIL lo_reissue: got %b exp 10", {hif.long_busy, hif.long_done}); end
        tick(); tick(); tick();                 // t+8
        #1;
        total++; if (hif.long_done !== 1'b1) begin bad++; $display("FAIL lo_done2: got %b exp 1", hif.long_done); end
        tick();
        #1;
        total++; if (hif.long_busy !== 1'b0) begin bad++; $display("FAIL lo_idle: got %b exp 0", hif.long_busy); end
    endtask

    task automatic test_freeze();
        do_reset();
        hif.ID_longop = 1; hif.ID_regwe = 1; hif.ID_RW = 11;
        tick();
        for (int i = 1; i <= 3; i++) begin
            set_idle();
            hif.MEM_memread = 1; hif.mem_ready = 0; hif.ID_rs = 5; hif.ID_rs_used = 1;
            #1;
            total++; if ({hif.freeze, hif.bubble, hif.stall, hif.long_done} !== 4'b1010) begin
                bad++; $display("FAIL fz_cycle%0d: got %b exp 1010", i, {hif.freeze, hif.bubble, hif.stall, hif.long_done}); end
            tick();
        end
        set_idle(); #1;
        total++; if ({hif.freeze, hif.long_done} !== 2'b01) begin bad++; $display("FAIL fz_done: got %b exp 01", {hif.freeze, hif.long_done}); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        hif.ID_longop = 1; hif.ID_regwe = 1; hif.ID_RW = 12;
        tick();                                 // t+1
        set_idle(); hif.ID_rs = 12; hif.ID_rs_used = 1;
        tick();                                 // t+2
        rst = 1; #1;
        total++; if ({hif.long_busy, hif.long_done, hif.stall} !== 3'b000) begin
            bad++; $display("FAIL rm_busy: got %b exp 000", {hif.long_busy, hif.long_done, hif.stall}); end
        total++; if (hif.stall_cycles !== '0) begin bad++; $display("FAIL rm_count: got %0d exp 0", hif.stall_cycles); end
        @(negedge clk);
        rst = 0;
        model_reset();
        set_idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (hif.long_done !== 1'b0) begin bad++; $display("FAIL rm_nodone%0d: got %b exp 0", i, hif.long_done); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hif.ID_rs = RW'($urandom_range(0, 3)); hif.ID_rt = RW'($urandom_range(0, 3));
            hif.ID_RW = RW'($urandom_range(0, 3));
            hif.ID_rs_used = 1'($urandom); hif.ID_rt_used = 1'($urandom); hif.ID_regwe = 1'($urandom);
            hif.ID_branch = ($urandom_range(0, 3) == 0); hif.ID_longop = ($urandom_range(0, 4) == 0);
            hif.EX_rs = RW'($urandom_range(0, 3)); hif.EX_rt = RW'($urandom_range(0, 3));
            hif.EX_RW = RW'($urandom_range(0, 3));
            hif.EX_regwe = 1'($urandom); hif.EX_memread = ($urandom_range(0, 3) == 0);
            hif.MEM_rt = RW'($urandom_range(0, 3)); hif.MEM_RW = RW'($urandom_range(0, 3));
            hif.MEM_regwe = 1'($urandom); hif.MEM_memread = ($urandom_range(0, 3) == 0);
            hif.MEM_ramwe = ($urandom_range(0, 3) == 0);
            hif.WB_RW = RW'($urandom_range(0, 3)); hif.WB_regwe = 1'($urandom);
            hif.mem_ready = ($urandom_range(0, 3) != 0);
            #1;
            eval_model();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL rand%0d: got %h exp %h", i, got_v, exp_v); end
            tick();
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        set_idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_ex_fwd();
        test_load_use();
        test_branch_load();
        test_long();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
